// File: rtl/queue_dispatcher.sv
// queue_dispatcher
//   Write-side dispatcher for a bank of QUEUE_QUANTITY FIFOs. Each accepted
//   upstream word is steered to the FIFO named by its destination index as a
//   registered one-cycle push strobe plus data. A one-entry holding stage
//   absorbs a word whose destination is almost-full and stalls the source.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   enb           : block enable; low freezes all state and suppresses pushes
//   in_valid      : upstream word present
//   in_data       : upstream word
//   in_dest       : destination queue index
//   in_ready      : word can be accepted this cycle (combinational)
//   buf_full      : per-FIFO almost-full flags
//   push          : one-hot registered write strobe
//   push_data     : registered write data
//   stalled       : a word is held waiting for its queue
//   pushed_count  : total pushes issued (wrapping)
//   stall_count   : enabled cycles blocked in HOLD (saturating)
module queue_dispatcher #(
  parameter int unsigned QUEUE_QUANTITY = 4,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned COUNT_BITS     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enb,
  input  logic                              in_valid,
  input  logic [DATA_BITS-1:0]              in_data,
  input  logic [$clog2(QUEUE_QUANTITY)-1:0] in_dest,
  output logic                              in_ready,
  input  logic [QUEUE_QUANTITY-1:0]         buf_full,
  output logic [QUEUE_QUANTITY-1:0]         push,
  output logic [DATA_BITS-1:0]              push_data,
  output logic                              stalled,
  output logic [COUNT_BITS-1:0]             pushed_count,
  output logic [COUNT_BITS-1:0]             stall_count
);

  localparam int unsigned DEST_BITS = $clog2(QUEUE_QUANTITY);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [DATA_BITS-1:0]      hold_data_q, hold_data_d;
  logic [DEST_BITS-1:0]      hold_dest_q, hold_dest_d;
  logic [QUEUE_QUANTITY-1:0] push_q, push_d;
  logic [DATA_BITS-1:0]      push_data_q, push_data_d;
  logic [COUNT_BITS-1:0]     pushed_q, pushed_d;
  logic [COUNT_BITS-1:0]     stall_q, stall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_dest_q <= '0;
      push_q      <= '0;
      push_data_q <= '0;
      pushed_q    <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_dest_q <= hold_dest_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      pushed_q    <= pushed_d;
      stall_q     <= stall_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_dest_d = hold_dest_q;
    push_d      = '0;
    push_data_d = push_data_q;
    pushed_d    = pushed_q;
    stall_d     = stall_q;
    if (enb) begin
      case (state_q)
        IDLE: begin
          // in_ready is implied here (enb high and IDLE), so in_valid is accept
          if (in_valid) begin
            if (!buf_full[in_dest]) begin
              push_d      = QUEUE_QUANTITY'(1) << in_dest;
              push_data_d = in_data;
              pushed_d    = pushed_q + COUNT_BITS'(1);
            end else begin
              hold_data_d = in_data;
              hold_dest_d = in_dest;
              state_d     = HOLD;
            end
          end
        end
        HOLD: begin
          // only the held word's own queue matters; no bypass by later words
          if (!buf_full[hold_dest_q]) begin
            push_d      = QUEUE_QUANTITY'(1) << hold_dest_q;
            push_data_d = hold_data_q;
            pushed_d    = pushed_q + COUNT_BITS'(1);
            state_d     = IDLE;
          end else if (stall_q != '1) begin
            stall_d = stall_q + COUNT_BITS'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign in_ready     = enb && (state_q == IDLE);
  assign stalled      = (state_q == HOLD);
  assign push         = push_q;
  assign push_data    = push_data_q;
  assign pushed_count = pushed_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_queue_dispatcher.sv
module tb_queue_dispatcher;

  localparam int unsigned QQ = 4;
  localparam int unsigned DB = 8;
  localparam int unsigned CB = 8;

  logic          clk = 1'b0;
  logic          rst, enb, in_valid, in_ready, stalled;
  logic [DB-1:0] in_data, push_data;
  logic [1:0]    in_dest;
  logic [QQ-1:0] buf_full, push;
  logic [CB-1:0] pushed_count, stall_count;

  queue_dispatcher #(
    .QUEUE_QUANTITY(QQ),
    .DATA_BITS(DB),
    .COUNT_BITS(CB)
  ) dut (
    .clk(clk), .rst(rst), .enb(enb),
    .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest),
    .in_ready(in_ready), .buf_full(buf_full),
    .push(push), .push_data(push_data), .stalled(stalled),
    .pushed_count(pushed_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Reference model: pending word (at most one) as a queue of {dest,data},
  // counters as plain integers, expected strobes as a scoreboard.
  typedef struct {
    int unsigned dest;
    int unsigned data;
  } word_t;
  typedef struct {
    int unsigned at_cyc;
    int unsigned vec;
    int unsigned data;
  } exp_t;

  word_t       held[$];
  exp_t        sb[$];
  int unsigned m_pushed = 0;
  int unsigned m_stall  = 0;
  int unsigned m_pd     = 0;
  bit          m_known  = 0;

  function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void expect_push(input int unsigned dest, input int unsigned data);
    exp_t e;
    e.at_cyc = cyc + 1;
    e.vec    = 1 << dest;
    e.data   = data;
    sb.push_back(e);
    m_pushed = (m_pushed + 1) % (1 << CB);
    m_pd     = data;
  endfunction

  task automatic step(input logic r, input logic e, input logic v, input logic [DB-1:0] d,
                      input logic [1:0] q, input logic [QQ-1:0] f);
    word_t w;
    @(negedge clk);
    rst = r; enb = e; in_valid = v; in_data = d; in_dest = q; buf_full = f;
    #1;
    if (m_known) begin
      chk("in_ready", in_ready, (e && held.size() == 0) ? 1 : 0);
      chk("stalled", stalled, (held.size() != 0) ? 1 : 0);
      chk("pushed_count", pushed_count, m_pushed);
      chk("stall_count", stall_count, m_stall);
      chk("push_data", push_data, m_pd);
    end
    if (r) begin
      held.delete();
      m_pushed = 0;
      m_stall  = 0;
      m_pd     = 0;
      m_known  = 1;
    end else if (e) begin
      if (held.size() == 0) begin
        if (v) begin
          if (!f[q]) expect_push(q, d);
          else begin
            w.dest = q;
            w.data = d;
            held.push_back(w);
          end
        end
      end else if (!f[held[0].dest]) begin
        w = held.pop_front();
        expect_push(w.dest, w.data);
      end else if (m_stall < (1 << CB) - 1) begin
        m_stall++;
      end
    end
  endtask

  // Monitor: every strobe the DUT presents must match the scoreboard head,
  // and every due expectation must have produced a strobe.
  always @(negedge clk) begin
    if (m_known) begin
      if (push != '0) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL push_unexpected: got push=%b data=0x%0h expected no push (cycle %0d)",
                   push, push_data, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.at_cyc != cyc || e.vec != push || e.data != push_data) begin
            n_err++;
            $display("FAIL push: got push=%b data=0x%0h cycle %0d expected push=%0b data=0x%0h cycle %0d",
                     push, push_data, cyc, e.vec, e.data, e.at_cyc);
          end
        end
      end else if (sb.size() != 0 && sb[0].at_cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        n_err++;
        $display("FAIL push_missing: got push=0 expected push=%0b data=0x%0h (cycle %0d)",
                 e.vec, e.data, cyc);
      end
    end
  end

  initial begin
    rst = 1'b1; enb = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0; buf_full = '0;

    // reset with a word offered
    step(1, 0, 1, 8'hEE, 2'd1, 4'b0000);
    step(1, 0, 1, 8'hEE, 2'd1, 4'b0000);
    step(0, 0, 0, 8'h00, 2'd0, 4'b0000);
    chk("reset_push", push, 0);
    chk("reset_push_data", push_data, 0);
    chk("reset_pushed_count", pushed_count, 0);

    // streaming to all four queues
    step(0, 1, 1, 8'hA1, 2'd0, 4'b0000);
    step(0, 1, 1, 8'hB2, 2'd1, 4'b0000);
    step(0, 1, 1, 8'hC3, 2'd2, 4'b0000);
    step(0, 1, 1, 8'hD4, 2'd3, 4'b0000);
    step(0, 1, 0, 8'h00, 2'd0, 4'b0000);
    step(0, 1, 0, 8'h00, 2'd0, 4'b0000);
    chk("stream_count", pushed_count, 4);

    // backpressure on queue 2 for three cycles
    step(0, 1, 1, 8'h55, 2'd2, 4'b0100);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 2'd0, 4'b0100);
    step(0, 1, 0, 8'h00, 2'd0, 4'b0000);
    step(0, 1, 0, 8'h00, 2'd0, 4'b0000);
    chk("bp_stall_count", stall_count, 3);
    chk("bp_stalled", stalled, 0);

    // head-of-line: a word for a free queue waits behind the held word
    step(0, 1, 1, 8'h55, 2'd2, 4'b0100);
    step(0, 1, 1, 8'h66, 2'd0, 4'b0100);
    step(0, 1, 1, 8'h66, 2'd0, 4'b0100);
    step(0, 1, 1, 8'h66, 2'd0, 4'b0000);
    step(0, 1, 1, 8'h66, 2'd0, 4'b0000);
    step(0, 1, 0, 8'h00, 2'd0, 4'b0000);

    // enable gating while held
    step(0, 1, 1, 8'h77, 2'd1, 4'b0010);
    step(0, 0, 0, 8'h00, 2'd0, 4'b0000);
    step(0, 0, 0, 8'h00, 2'd0, 4'b0000);
    chk("enb_push", push, 0);
    step(0, 1, 0, 8'h00, 2'd0, 4'b0000);
    step(0, 1, 0, 8'h00, 2'd0, 4'b0000);

    // reset in HOLD discards the word
    step(0, 1, 1, 8'h88, 2'd3, 4'b1000);
    step(1, 0, 0, 8'h00, 2'd0, 4'b0000);
    step(0, 1, 0, 8'h00, 2'd0, 4'b0000);
    step(0, 1, 0, 8'h00, 2'd0, 4'b0000);
    chk("rst_hold_stalled", stalled, 0);

    // pushed_count wrap
    for (int i = 0; i < 257; i++)
      step(0, 1, 1, 8'($urandom), 2'($urandom), 4'b0000);
    step(0, 1, 0, 8'h00, 2'd0, 4'b0000);
    chk("wrap_pushed_count", pushed_count, 1);

    // stall_count saturation
    step(0, 1, 1, 8'h99, 2'd0, 4'b0001);
    for (int i = 0; i < 300; i++) step(0, 1, 0, 8'h00, 2'd0, 4'b0001);
    step(0, 1, 0, 8'h00, 2'd0, 4'b0000);
    chk("sat_stall_count", stall_count, 255);
    step(0, 1, 0, 8'h00, 2'd0, 4'b0000);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [QQ-1:0] f;
      f = 4'($urandom) & 4'($urandom);
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
           1'($urandom), 8'($urandom), 2'($urandom), f);
    end

    // drain and confirm nothing is left outstanding
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 2'd0, 4'b0000);
    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/queue_dispatcher.md
Name: queue_dispatcher

Overview:
- Write-side counterpart to the round-robin read arbiter. Takes one incoming word per cycle, tagged with a destination queue index, and issues a one-cycle push strobe plus data into the matching per-queue FIFO.
- Uses a one-entry holding stage to respect per-queue almost-full backpressure and reports the stall to the upstream source through in_ready.
- Sits between the packet source and the bank of QUEUE_QUANTITY FIFOs that the arbiter later drains.

Parameters:
- QUEUE_QUANTITY, 4, number of destination FIFOs; power of two, >= 2.
- DATA_BITS, 8, width of the data word.
- COUNT_BITS, 8, width of the pushed_count and stall_count statistics counters.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- enb  input  1  block enable; when low, state is frozen and no push is issued.
- in_valid  input  1  upstream word present.
- in_data  input  DATA_BITS  upstream word.
- in_dest  input  $clog2(QUEUE_QUANTITY)  destination queue index.
- in_ready  output  1  dispatcher can accept a word this cycle (combinational).
- buf_full  input  QUEUE_QUANTITY  per-FIFO almost-full; bit i high means queue i must not be pushed.
- push  output  QUEUE_QUANTITY  one-hot write strobe, registered, one cycle wide.
- push_data  output  DATA_BITS  data for the push, registered.
- stalled  output  1  high while a word is held waiting for its queue.
- pushed_count  output  COUNT_BITS  total pushes issued; wraps.
- stall_count  output  COUNT_BITS  enabled cycles spent blocked in HOLD; saturates.

Behaviour:
- Reset (rst high at posedge): state=IDLE, push=0, push_data=0, hold_data=0, hold_dest=0, pushed_count=0, stall_count=0. rst has priority over enb. rst while in HOLD discards the held word.
- in_ready = enb && (state==IDLE). accept = in_valid && in_ready.
- stalled = (state==HOLD), taken directly from the state register.
- States are IDLE and HOLD.
- IDLE, accept, buf_full[in_dest]==0:
  - next edge: push = onehot(in_dest), push_data = in_data, pushed_count+1.
  - Stay in IDLE. Latency is one cycle from accept to strobe.
  - Back-to-back accepts give a push on every cycle.
- IDLE, accept, buf_full[in_dest]==1:
  - next edge: hold_data = in_data, hold_dest = in_dest, push = 0, go to HOLD.
  - stall_count does not change on this edge.
- IDLE, no accept: push = 0; push_data keeps its last value.
- HOLD, enb high, buf_full[hold_dest]==0:
  - next edge: push = onehot(hold_dest), push_data = hold_data, pushed_count+1, go to IDLE.
  - in_ready stays low during this cycle, so no new word is accepted in the release cycle.
- HOLD, enb high, buf_full[hold_dest]==1:
  - push = 0; stall_count+1, saturating at 2^COUNT_BITS-1.
- enb low in any state: push = 0, state and hold registers unchanged, counters unchanged, in_ready = 0.
- Only buf_full[hold_dest] affects a held word. Full flags of other queues are ignored, so there is no reordering and no bypass of the held word.
- buf_full is sampled in the cycle the decision is made; the FIFO write lands one cycle later. FIFOs must therefore assert almost-full with at least 1 free entry.
- pushed_count wraps from 2^COUNT_BITS-1 to 0.
- push is always zero or one-hot, never multi-hot.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> push=0, push_data=0, in_ready=0 during reset, both counters 0, stalled=0.
- Streaming: enb=1, buf_full=0000, words 0xA1/d0, 0xB2/d1, 0xC3/d2, 0xD4/d3 on consecutive cycles -> push = 0001, 0010, 0100, 1000 on the 4 following cycles with matching push_data; pushed_count=4.
- Backpressure: buf_full=0100, word 0x55/d2 -> stalled=1, in_ready=0, no push. Keep 3 cycles, then buf_full=0000 -> push=0100 with push_data=0x55 one cycle later, stall_count=3, stalled=0 after.
- Head-of-line: in HOLD for d2, present 0x66/d0 with buf_full=0100 -> 0x66 not accepted and push stays 0. Release d2 -> 0x55 pushed first, then 0x66 accepted and pushed to queue 0.
- enb gating: in HOLD, drop enb for 2 cycles while buf_full clears -> no push, stall_count unchanged. Raise enb -> push issued the next cycle.
- Reset mid-hold and wrap: assert rst in HOLD -> state IDLE, held word never pushed. Then issue 257 pushes with COUNT_BITS=8 -> pushed_count=1. Then stall 300 cycles -> stall_count=255.
